// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - debounced button levels to press/auto-repeat events on one valid/ready stream
// Round-robin arbiter over per-button pending bits; bursts for one button coalesce into a single event.
module button_event_arbiter #(
   parameter int width         = 4,
   parameter int repeat_delay  = 20,
   parameter int repeat_period = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [width-1:0]         buttons,
   output logic                     event_valid,
   input  logic                     event_ready,
   output logic [$clog2(width)-1:0] event_index,
   output logic                     event_repeat,
   output logic [width-1:0]         pending
);

   localparam int IW   = $clog2(width);
   localparam int CMAX = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] DLY_M1 = CW'(repeat_delay - 1);
   localparam logic [CW-1:0] PER_M1 = CW'(repeat_period - 1);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t            state_q, state_d;
   logic [width-1:0]  prev_q;
   logic [width-1:0]  armed_q, armed_d;
   logic [width-1:0]  phase_q, phase_d;
   logic [width-1:0]  rep_flag_q, rep_flag_d;
   logic [width-1:0]  pending_q, pending_d;
   logic [CW-1:0]     hold_q [width];
   logic [CW-1:0]     hold_d [width];
   logic [IW-1:0]     last_grant_q, last_grant_d;
   logic              valid_q, valid_d;
   logic [IW-1:0]     index_q, index_d;
   logic              repeat_q, repeat_d;

   logic [width-1:0]  new_evt;
   logic [width-1:0]  new_rep;
   logic [width-1:0]  clr;
   logic              found;
   logic [IW-1:0]     gidx;
   logic [IW-1:0]     cand;
   int                cand_i;

   // phase_q distinguishes the initial delay from the steady repeat period
   always_comb begin : button_comb
      new_evt = '0;
      new_rep = '0;
      armed_d = armed_q;
      phase_d = phase_q;
      for (int i = 0; i < width; i++) begin
         hold_d[i] = hold_q[i];
         if (buttons[i] && !prev_q[i]) begin
            new_evt[i] = 1'b1;
            armed_d[i] = 1'b1;
            phase_d[i] = 1'b0;
            hold_d[i]  = '0;
         end else if (buttons[i] && armed_q[i]) begin
            if (hold_q[i] == (phase_q[i] ? PER_M1 : DLY_M1)) begin
               new_evt[i] = 1'b1;
               new_rep[i] = 1'b1;
               phase_d[i] = 1'b1;
               hold_d[i]  = '0;
            end else begin
               hold_d[i] = hold_q[i] + 1'b1;
            end
         end else if (!buttons[i]) begin
            armed_d[i] = 1'b0;
            hold_d[i]  = '0;
         end
      end
   end

   always_comb begin : search_comb
      found  = 1'b0;
      gidx   = '0;
      cand_i = 0;
      cand   = '0;
      for (int off = 1; off <= width; off++) begin
         cand_i = int'(last_grant_q) + off;
         if (cand_i >= width) cand_i = cand_i - width;
         cand = IW'(cand_i);
         if (!found && pending_q[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
   end

   always_comb begin : arb_comb
      state_d      = state_q;
      valid_d      = valid_q;
      index_d      = index_q;
      repeat_d     = repeat_q;
      last_grant_d = last_grant_q;
      clr          = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               index_d   = gidx;
               repeat_d  = rep_flag_q[gidx];
               valid_d   = 1'b1;
               clr[gidx] = 1'b1;
               state_d   = PRESENT;
            end
         end
         PRESENT: begin
            if (event_ready) begin
               valid_d      = 1'b0;
               last_grant_d = index_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // a fresh event for the granted button outranks the grant's clear
      pending_d  = (pending_q & ~clr) | new_evt;
      rep_flag_d = rep_flag_q;
      for (int i = 0; i < width; i++) begin
         if (new_evt[i] && !new_rep[i]) rep_flag_d[i] = 1'b0;
         else if (new_rep[i] && !pending_q[i]) rep_flag_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      prev_q <= buttons;
      if (!rst_n) begin
         state_q      <= IDLE;
         armed_q      <= '0;
         phase_q      <= '0;
         rep_flag_q   <= '0;
         pending_q    <= '0;
         last_grant_q <= IW'(width - 1);
         valid_q      <= 1'b0;
         index_q      <= '0;
         repeat_q     <= 1'b0;
         for (int i = 0; i < width; i++) hold_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         phase_q      <= phase_d;
         rep_flag_q   <= rep_flag_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         valid_q      <= valid_d;
         index_q      <= index_d;
         repeat_q     <= repeat_d;
         for (int i = 0; i < width; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign event_valid  = valid_q;
   assign event_index  = index_q;
   assign event_repeat = repeat_q;
   assign pending      = pending_q;

endmodule
